// File: rtl/cpu_bus_pkg.sv
// Shared types and memory-map constants for the 68000 bus responder and
// anything else that needs to interpret CPU addresses (e.g. debug monitor).
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_MEM,
    ST_ACK,
    ST_ERR,
    ST_HOLD
  } state_t;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_ROM,
    RGN_IO,
    RGN_VIA,
    RGN_IACK,
    RGN_NONE
  } region_t;

  // Map boundaries (first byte address of each region)
  localparam logic [23:0] OVL_LIMIT  = 24'h100000;
  localparam logic [23:0] RAM_END    = 24'h400000;
  localparam logic [23:0] IO_BASE    = 24'h800000;
  localparam logic [23:0] VIA_BASE   = 24'hE00000;
  localparam logic [23:0] UNMAP_BASE = 24'hF00000;

  // Function code for an interrupt-acknowledge cycle
  localparam logic [2:0] FC_IACK = 3'b111;

  // Saturating 8-bit increment for event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// Combinational 68000 address/function-code decoder. Maps a bus cycle onto
// one of the Plus Too regions in priority order. Boundaries are all even, so
// address bit 0 has no influence on the result.
module cpu_addr_decode
  import cpu_bus_pkg::*;
#(
  parameter logic [23:0] ROM_TOP = 24'h402000
) (
  input  logic [23:0] addr,
  input  logic [2:0]  fc,
  input  logic        overlay,
  output region_t     region
);

  // Priority decode: IACK first, then overlay ROM, then the linear map
  always_comb begin
    region = RGN_NONE;
    if (fc == FC_IACK)
      region = RGN_IACK;
    else if (overlay && (addr < OVL_LIMIT))
      region = RGN_ROM;
    else if (addr < RAM_END)
      region = RGN_RAM;
    else if (addr < ROM_TOP)
      region = RGN_ROM;
    else if (addr < IO_BASE)
      region = RGN_NONE;
    else if (addr < VIA_BASE)
      region = RGN_IO;
    else if (addr < UNMAP_BASE)
      region = RGN_VIA;
    else
      region = RGN_NONE;
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// 68000 bus-slave responder: decodes each address-strobe cycle into a region
// select and terminates it with exactly one of DTACK, VPA or BERR. Memory
// regions wait for memReady with a timeout so a stalled arbiter turns into a
// bus error instead of a hung CPU.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [23:0] ROM_TOP        = 24'h402000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [23:0] cpuAddr,
  input  logic        _cpuAS,
  input  logic        _cpuUDS,
  input  logic        _cpuLDS,
  input  logic        _cpuRW,
  input  logic [2:0]  cpuFC,
  input  logic        overlay,
  input  logic        memReady,
  output logic        selRAM,
  output logic        selROM,
  output logic        selIO,
  output logic        selVIA,
  output logic        _cpuDTACK,
  output logic        _cpuVPA,
  output logic        _cpuBERR,
  output logic [7:0]  berrCount
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  region_t          region;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ack_vpa;   // chosen acknowledge: 1 = VPA, 0 = DTACK

  // Data strobes and direction go straight to memory; the response ignores them
  logic unused_pins;
  assign unused_pins = ^{_cpuUDS, _cpuLDS, _cpuRW};

  cpu_addr_decode #(
    .ROM_TOP (ROM_TOP)
  ) u_decode (
    .addr    (cpuAddr),
    .fc      (cpuFC),
    .overlay (overlay),
    .region  (region)
  );

  // Bus-cycle FSM with registered selects, terminations and error counter
  always_ff @(posedge clk32) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ack_vpa   <= 1'b0;
      selRAM    <= 1'b0;
      selROM    <= 1'b0;
      selIO     <= 1'b0;
      selVIA    <= 1'b0;
      _cpuDTACK <= 1'b1;
      _cpuVPA   <= 1'b1;
      _cpuBERR  <= 1'b1;
      berrCount <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!_cpuAS) state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (_cpuAS) begin
            // Cycle aborted before anything was committed
            state <= ST_IDLE;
          end else begin
            selRAM <= (region == RGN_RAM);
            selROM <= (region == RGN_ROM);
            selIO  <= (region == RGN_IO);
            selVIA <= (region == RGN_VIA);
            cnt    <= '0;
            case (region)
              RGN_RAM, RGN_ROM, RGN_IO: state <= ST_WAIT_MEM;
              RGN_VIA, RGN_IACK: begin
                ack_vpa <= 1'b1;
                state   <= ST_ACK;
              end
              default: begin
                berrCount <= sat_inc8(berrCount);
                state     <= ST_ERR;
              end
            endcase
          end
        end

        ST_WAIT_MEM: begin
          if (_cpuAS) begin
            selRAM <= 1'b0;
            selROM <= 1'b0;
            selIO  <= 1'b0;
            selVIA <= 1'b0;
            state  <= ST_IDLE;
          end else if (memReady) begin
            // memReady takes precedence over a timeout expiring on the same edge
            ack_vpa <= 1'b0;
            state   <= ST_ACK;
          end else if (cnt == CNT_LAST) begin
            berrCount <= sat_inc8(berrCount);
            state     <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_ACK: begin
          if (ack_vpa) _cpuVPA   <= 1'b0;
          else         _cpuDTACK <= 1'b0;
          state <= ST_HOLD;
        end

        ST_ERR: begin
          _cpuBERR <= 1'b0;
          state    <= ST_HOLD;
        end

        ST_HOLD: begin
          if (_cpuAS) begin
            _cpuDTACK <= 1'b1;
            _cpuVPA   <= 1'b1;
            _cpuBERR  <= 1'b1;
            selRAM    <= 1'b0;
            selROM    <= 1'b0;
            selIO     <= 1'b0;
            selVIA    <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: directed scenarios plus random
// bus cycles, predicted by a map/latency model of the responder's behaviour.
module tb_cpu_bus_responder;

  localparam int T = 64;

  logic        clk32 = 1'b0;
  logic        reset;
  logic [23:0] cpuAddr;
  logic        _cpuAS, _cpuUDS, _cpuLDS, _cpuRW;
  logic [2:0]  cpuFC;
  logic        overlay, memReady;
  logic        selRAM, selROM, selIO, selVIA;
  logic        _cpuDTACK, _cpuVPA, _cpuBERR;
  logic [7:0]  berrCount;

  int checks = 0;
  int errors = 0;
  int berr_model = 0;

  typedef enum {M_RAM, M_ROM, M_IO, M_VIA, M_IACK, M_NONE} mrgn_t;

  always #5 clk32 = ~clk32;

  cpu_bus_responder #(
    .ROM_TOP        (24'h402000),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk32     (clk32),
    .reset     (reset),
    .cpuAddr   (cpuAddr),
    ._cpuAS    (_cpuAS),
    ._cpuUDS   (_cpuUDS),
    ._cpuLDS   (_cpuLDS),
    ._cpuRW    (_cpuRW),
    .cpuFC     (cpuFC),
    .overlay   (overlay),
    .memReady  (memReady),
    .selRAM    (selRAM),
    .selROM    (selROM),
    .selIO     (selIO),
    .selVIA    (selVIA),
    ._cpuDTACK (_cpuDTACK),
    ._cpuVPA   (_cpuVPA),
    ._cpuBERR  (_cpuBERR),
    .berrCount (berrCount)
  );

  // Memory map reasoned in megabyte units
  function automatic mrgn_t model_region(input logic [23:0] a, input logic [2:0] fc,
                                         input logic ovl);
    int unsigned x;
    int unsigned mb;
    x  = a;
    mb = x / 32'h100000;
    if (fc == 3'd7)            return M_IACK;
    if (ovl && mb == 0)        return M_ROM;
    if (mb < 4)                return M_RAM;
    if (x < 32'h402000)        return M_ROM;
    if (mb < 8)                return M_NONE;
    if (mb < 14)               return M_IO;
    if (mb == 14)              return M_VIA;
    return M_NONE;
  endfunction

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dtack"}, _cpuDTACK, 1);
    chk({tag, "_vpa"},   _cpuVPA, 1);
    chk({tag, "_berr"},  _cpuBERR, 1);
    chk({tag, "_sels"},  {selRAM, selROM, selIO, selVIA}, 0);
    chk({tag, "_berrcnt"}, berrCount, 0);
  endtask

  // One complete bus cycle. ready_edge: edge index at which memReady is
  // sampled high (0 = never). The model predicts the termination and its edge.
  task automatic run_cycle(input logic [23:0] a, input logic [2:0] fc, input logic ovl,
                           input int ready_edge);
    mrgn_t r;
    int term, kind, nhold;
    r = model_region(a, fc, ovl);
    if (r == M_VIA || r == M_IACK) begin
      term = 2; kind = 1;
    end else if (r == M_NONE) begin
      term = 2; kind = 2;
    end else if (ready_edge >= 2 && ready_edge <= T + 1) begin
      term = ready_edge + 1; kind = 0;
    end else begin
      term = T + 2; kind = 2;
    end
    if (kind == 2 && berr_model < 255) berr_model++;

    cpuAddr = a;
    cpuFC   = fc;
    overlay = ovl;
    _cpuRW  = 1'($urandom_range(0, 1));
    _cpuUDS = 1'($urandom_range(0, 1));
    _cpuLDS = 1'($urandom_range(0, 1));
    _cpuAS  = 1'b0;
    for (int e = 0; e <= term; e++) begin
      if (r == M_VIA || r == M_IACK || r == M_NONE || e < 2)
        memReady = 1'($urandom_range(0, 1));
      else
        memReady = (e == ready_edge);
      tick();
      if (e == 1)
        chk($sformatf("sel@%06h", a), {selRAM, selROM, selIO, selVIA},
            {r == M_RAM, r == M_ROM, r == M_IO, r == M_VIA});
      chk($sformatf("dtack@%06h e%0d", a, e), _cpuDTACK, !(kind == 0 && e == term));
      chk($sformatf("vpa@%06h e%0d",   a, e), _cpuVPA,   !(kind == 1 && e == term));
      chk($sformatf("berr@%06h e%0d",  a, e), _cpuBERR,  !(kind == 2 && e == term));
      if (e == term) chk("berrcount", berrCount, berr_model);
    end
    memReady = 1'b0;
    nhold = $urandom_range(0, 2);
    repeat (nhold) begin
      tick();
      chk("hold_strobe", {_cpuDTACK, _cpuVPA, _cpuBERR},
          {kind != 0, kind != 1, kind != 2});
    end
    _cpuAS = 1'b1;
    tick();
    chk("release_strobes", {_cpuDTACK, _cpuVPA, _cpuBERR}, 3'b111);
    chk("release_sels", {selRAM, selROM, selIO, selVIA}, 0);
  endtask

  // Memory cycle abandoned by raising _cpuAS at abort_edge (DECODE or WAIT_MEM)
  task automatic abort_cycle(input logic [23:0] a, input int abort_edge);
    cpuAddr = a; cpuFC = 3'd5; overlay = 1'b0; memReady = 1'b0;
    _cpuAS = 1'b0;
    for (int e = 0; e < abort_edge; e++) begin
      tick();
      chk("abort_pre_strobes", {_cpuDTACK, _cpuVPA, _cpuBERR}, 3'b111);
    end
    _cpuAS = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_strobes", {_cpuDTACK, _cpuVPA, _cpuBERR}, 3'b111);
      chk("abort_sels", {selRAM, selROM, selIO, selVIA}, 0);
      chk("abort_berrcnt", berrCount, berr_model);
    end
  endtask

  logic [23:0] bnd [7];
  logic [23:0] ra;
  logic [2:0]  rfc;
  int          rdy;

  initial begin
    bnd = '{24'h000000, 24'h100000, 24'h400000, 24'h402000,
            24'h800000, 24'hE00000, 24'hF00000};
    reset = 1'b1; _cpuAS = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1; _cpuRW = 1'b1;
    cpuAddr = '0; cpuFC = 3'd5; overlay = 1'b0; memReady = 1'b0;
    repeat (2) tick();
    check_reset_values("reset_init");
    reset = 1'b0;
    tick();

    // Directed cycles
    run_cycle(24'h000100, 3'd5, 1'b0, 4);        // RAM, DTACK at edge 5
    run_cycle(24'hEFE1FE, 3'd5, 1'b0, 0);        // VIA, VPA at edge 2
    run_cycle(24'h402000, 3'd5, 1'b0, 0);        // unmapped, BERR at edge 2
    run_cycle(24'h9FFFF8, 3'd5, 1'b0, 0);        // IO timeout, BERR at edge 66
    run_cycle(24'h9FFFF8, 3'd5, 1'b0, T + 1);    // ready on expiry edge: DTACK
    run_cycle(24'h000008, 3'd5, 1'b1, 3);        // overlay ROM
    run_cycle(24'h000008, 3'd5, 1'b0, 3);        // same address, RAM
    run_cycle(24'h123456, 3'd7, 1'b0, 0);        // IACK autovector
    run_cycle(24'h401FFE, 3'd6, 1'b0, 2);        // last ROM word, fastest ready

    // Abort in WAIT_MEM, then reset asserted mid-cycle
    abort_cycle(24'h000100, 4);
    abort_cycle(24'h800000, 1);
    cpuAddr = 24'h800010; _cpuAS = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    berr_model = 0;
    check_reset_values("reset_wait");
    reset = 1'b0; _cpuAS = 1'b1;
    tick();
    run_cycle(24'h200000, 3'd5, 1'b0, 5);

    // Reset pulsed during HOLD
    cpuAddr = 24'hE00000; cpuFC = 3'd5; _cpuAS = 1'b0;
    repeat (3) tick();
    chk("hold_vpa_before_reset", _cpuVPA, 0);
    reset = 1'b1;
    tick();
    berr_model = 0;
    check_reset_values("reset_hold");
    reset = 1'b0; _cpuAS = 1'b1;
    tick();
    run_cycle(24'hE80000, 3'd5, 1'b0, 0);

    // Random cycles, biased toward map boundaries
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        ra = 24'($urandom);
      else
        ra = bnd[$urandom_range(0, 6)] + 24'($urandom_range(0, 4) * 2) - 24'd4;
      rfc = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      case ($urandom_range(0, 9))
        0:       rdy = 0;
        1:       rdy = T + 1;
        default: rdy = $urandom_range(2, 10);
      endcase
      run_cycle(ra, rfc, 1'($urandom_range(0, 1)), rdy);
    end

    // Saturate the bus-error counter
    for (int i = 0; i < 300; i++)
      run_cycle((i % 2 == 0) ? 24'h402000 : 24'hF00000, 3'd5, 1'b0, 0);
    chk("berrcount_saturated", berrCount, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Synthesizable 68000 bus-slave responder for the Plus Too core: sits between the CPU's asynchronous bus strobes and the memory/peripheral blocks, and decodes every address-strobe cycle into a region select. It answers each cycle with exactly one termination: `_cpuDTACK`, `_cpuVPA` or `_cpuBERR`. Unimplemented address space and stalled memory are turned into clean bus errors, so the CPU traps instead of hanging.

## Interface
Parameters:
- `ROM_TOP`, default 24'h402000: first byte address above implemented ROM.
- `TIMEOUT_CYCLES`, default 64: `clk32` cycles to wait for `memReady` before issuing BERR.

Ports:
- `clk32`, in, 1: system clock. One clock only; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `cpuAddr`, in, 24: CPU byte address; bit 0 is ignored.
- `_cpuAS`, in, 1: address strobe, active low.
- `_cpuUDS`, in, 1: upper data strobe, active low.
- `_cpuLDS`, in, 1: lower data strobe, active low.
- `_cpuRW`, in, 1: 1 = read.
- `cpuFC`, in, 3: function code.
- `overlay`, in, 1: 1 = ROM is mirrored at 000000–0FFFFF.
- `memReady`, in, 1: one-cycle pulse from the memory arbiter meaning data is valid or the write has been accepted.
- `selRAM`, `selROM`, `selIO`, `selVIA`, out, 1 each: registered region selects.
- `_cpuDTACK`, `_cpuVPA`, `_cpuBERR`, out, 1 each: active-low terminations.
- `berrCount`, out, 8: saturating count of bus errors issued.

## Operation
Memory map, evaluated in priority order:
- `cpuFC`==3'b111 (IACK): VPA, autovector.
- 000000–0FFFFF with `overlay`=1: ROM.
- 000000–3FFFFF: RAM.
- 400000–`ROM_TOP`-1: ROM.
- `ROM_TOP`–7FFFFF: unmapped.
- 800000–DFFFFF: IO (SCC/IWM/SCSI); waits for `memReady`.
- E00000–EFFFFF: VIA; VPA.
- F00000–FFFFFF: unmapped.

State machine: IDLE, DECODE, WAIT_MEM, ACK, ERR, HOLD.
- IDLE: `_cpuAS` sampled low moves to DECODE.
- DECODE: latch the address and drive the region select.
  - RAM, ROM or IO goes to WAIT_MEM.
  - VIA or IACK goes to ACK with VPA.
  - Unmapped goes to ERR.
- WAIT_MEM: the timeout counter counts up from 0.
  - `memReady` goes to ACK with DTACK.
  - Counter reaching `TIMEOUT_CYCLES`-1 goes to ERR.
- ACK or ERR: assert the chosen strobe, then go to HOLD.
- HOLD: keep the strobe asserted until `_cpuAS` is sampled high. Next edge: all strobes and selects deassert, state returns to IDLE.
- `berrCount` increments on entry to ERR and saturates at 8'hFF.
- At most one of DTACK, VPA, BERR is ever low.

## Timing
- Reset values: `_cpuDTACK`=`_cpuVPA`=`_cpuBERR`=1, all `sel*`=0, `berrCount`=0, state IDLE.
- Counting from the edge where `_cpuAS` is first sampled low (edge 0):
  - Selects are valid at edge 1.
  - VPA and unmapped BERR are low at edge 2.
  - DTACK goes low on the edge after the `memReady` pulse.
- Timeout BERR is low `TIMEOUT_CYCLES`+2 edges after edge 0.
- `memReady` arriving in the same cycle the counter expires: DTACK wins and no BERR is issued.
- `memReady` outside WAIT_MEM is ignored.
- `_cpuAS` sampled high in DECODE or WAIT_MEM (aborted cycle):
  - Return to IDLE on that edge.
  - No strobe is asserted and `berrCount` is unchanged.
- `reset` asserted mid-cycle: reset values on the next edge, regardless of state.
- Back-to-back cycles: `_cpuAS` low again on the edge right after HOLD→IDLE is accepted with no extra idle cycle.
- `_cpuUDS`/`_cpuLDS` do not gate the response; they pass through to memory.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - The state enum.
  - The region enum (RGN_RAM, RGN_ROM, RGN_IO, RGN_VIA, RGN_IACK, RGN_NONE).
  - The map boundary constants (24'h400000, 24'h800000, 24'hE00000, 24'hF00000, overlay limit 24'h100000).
- Sub-module `cpu_addr_decode`: combinational `cpuAddr`/`cpuFC`/`overlay` to region. It is reused by the top-level debug monitor.
- The responder itself holds the FSM, the timeout counter (width $clog2(`TIMEOUT_CYCLES`)) and `berrCount`.

## Test plan
- Read at 24'h000100, `overlay`=0, `memReady` pulsed 3 cycles after DECODE:
  - `selRAM`=1 at edge 1.
  - DTACK low at edge 5.
  - DTACK high one edge after `_cpuAS` rises.
- Read at 24'hEFE1FE: `selVIA`=1, VPA low at edge 2, DTACK and BERR stay high.
- Read at 24'h402000: BERR low at edge 2, `berrCount`=1. Then 300 repeated unmapped cycles: `berrCount` saturates at 8'hFF.
- IO read at 24'h9FFFF8 with no `memReady`: BERR low at edge 66. Repeat with `memReady` on the expiry cycle: DTACK only.
- `overlay`=1, read at 24'h000008: `selROM`=1. Same read with `overlay`=0: `selRAM`=1.
- Two reset cases, each with all outputs checked against reset values next edge and normal operation on the following cycle:
  - `_cpuAS` released while in WAIT_MEM: no strobe ever asserted.
  - `reset` pulsed during HOLD.
